// File: rtl/csla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-select adder.
package csla_pkg;

  localparam int CSLA_WIDTH_DEF = 16;
  localparam int CSLA_BLK_DEF   = 4;

  function automatic int nseg(input int width, input int blk);
    return width / blk;
  endfunction

  function automatic bit cfg_ok(input int width, input int blk);
    return (blk >= 2) && (width >= blk) && ((width % blk) == 0);
  endfunction

  // Stage k register = k+1 finished sum segments, the a/b bits not yet added, and a carry,
  // i.e. 2*width+1-(k+1)*blk bits; stages are packed back to back from bit 0.
  function automatic int st_off(input int k, input int width, input int blk);
    return k * (2 * width + 1) - (blk * k * (k + 1)) / 2;
  endfunction

endpackage

// File: rtl/csla_seg.sv
// One BLK-bit carry-select segment: ripple adder with cin=0, BEC for the cin=1 result, select mux.
module csla_seg
  import csla_pkg::*;
#(
  parameter int BLK = CSLA_BLK_DEF
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  input  logic           sel_i,
  output logic [BLK-1:0] sum_o,
  output logic           cout_o
);

  logic [BLK:0] r0;
  logic [BLK:0] r1;

  always_comb begin
    logic c;
    c  = 1'b0;
    r0 = '0;
    for (int i = 0; i < BLK; i++) begin
      r0[i] = a_i[i] ^ b_i[i] ^ c;
      c     = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    r0[BLK] = c;
  end

  // Excess-1: bit i toggles when every lower bit is 1. {c0,s0} never reaches all-ones.
  always_comb begin
    logic t;
    r1    = '0;
    r1[0] = ~r0[0];
    t     = r0[0];
    for (int i = 1; i <= BLK; i++) begin
      r1[i] = r0[i] ^ t;
      t     = t & r0[i];
    end
  end

  assign {cout_o, sum_o} = sel_i ? r1 : r0;

endmodule

// File: rtl/csla_bec_pipe.sv
// Streaming carry-select adder, one BLK segment per pipeline stage, valid/ready handshake.
// Optional signed-overflow output enabled by defining CSLA_OVF_EN.
module csla_bec_pipe
  import csla_pkg::*;
#(
  parameter int WIDTH = CSLA_WIDTH_DEF,
  parameter int BLK   = CSLA_BLK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CSLA_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NSEG = nseg(WIDTH, BLK);
  localparam int STW  = st_off(NSEG, WIDTH, BLK);
  localparam int LOFF = st_off(NSEG - 1, WIDTH, BLK);

  if (!cfg_ok(WIDTH, BLK)) begin : g_cfg_chk
    $error("csla_bec_pipe: WIDTH must be a multiple of BLK and BLK must be >= 2");
  end

  logic            en;
  logic [NSEG-1:0] vld_pipe_q;
  logic [STW-1:0]  st_d;
  logic [STW-1:0]  st_q;
`ifdef CSLA_OVF_EN
  logic            ovf_d;
  logic            ovf_q;
`endif

  assign out_valid = vld_pipe_q[NSEG-1];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int SW  = (k + 1) * BLK;
    localparam int RW  = WIDTH - SW;
    localparam int PW  = SW + 2 * RW + 1;
    localparam int OFF = st_off(k, WIDTH, BLK);

    logic [BLK-1:0] a_seg;
    logic [BLK-1:0] b_seg;
    logic           sel;
    logic [BLK-1:0] s;
    logic           c;

    csla_seg #(.BLK(BLK)) u_seg (
      .a_i   (a_seg),
      .b_i   (b_seg),
      .sel_i (sel),
      .sum_o (s),
      .cout_o(c)
    );

    if (k == 0) begin : g_head
      assign a_seg = in_a[BLK-1:0];
      assign b_seg = in_b[BLK-1:0];
      assign sel   = in_cin;
      if (RW > 0) begin : g_fwd
        assign st_d[OFF +: PW] = {c, in_b[WIDTH-1:BLK], in_a[WIDTH-1:BLK], s};
      end else begin : g_end
        assign st_d[OFF +: PW] = {c, s};
      end
    end else begin : g_body
      localparam int PSW  = k * BLK;
      localparam int PRW  = WIDTH - PSW;
      localparam int PPW  = PSW + 2 * PRW + 1;
      localparam int POFF = st_off(k - 1, WIDTH, BLK);

      // Previous stage layout, LSB first: done sum, remaining a, remaining b, carry.
      logic [PPW-1:0] prev;
      assign prev  = st_q[POFF +: PPW];
      assign a_seg = prev[PSW +: BLK];
      assign b_seg = prev[PSW + PRW +: BLK];
      assign sel   = prev[PPW-1];
      if (RW > 0) begin : g_fwd
        assign st_d[OFF +: PW] = {c, prev[PSW + PRW + BLK +: RW], prev[PSW + BLK +: RW],
                                  s, prev[PSW-1:0]};
      end else begin : g_end
        assign st_d[OFF +: PW] = {c, s, prev[PSW-1:0]};
      end
    end

`ifdef CSLA_OVF_EN
    if (k == NSEG - 1) begin : g_ovf
      assign ovf_d = (a_seg[BLK-1] == b_seg[BLK-1]) && (s[BLK-1] != a_seg[BLK-1]);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      st_q       <= '0;
`ifdef CSLA_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else if (en) begin
      vld_pipe_q[0] <= in_valid;
      for (int k = 1; k < NSEG; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
      st_q <= st_d;
`ifdef CSLA_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign out_sum  = st_q[LOFF +: WIDTH];
  assign out_cout = st_q[LOFF + WIDTH];
`ifdef CSLA_OVF_EN
  assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_csla_bec_pipe.sv
// Bench for csla_bec_pipe: 16/4 and 32/4 instances in lockstep against a queue-based adder model.
// Checks out_ovf as well when CSLA_OVF_EN is defined.
module tb_csla_bec_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_cin = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic [31:0] a32 = '0, b32 = '0, s32;
  logic        ir16, ov16, c16, f16;
  logic        ir32, ov32, c32, f32;

  int nvec = 0;
  int nerr = 0;

  logic [17:0] q16[$];
  logic [33:0] q32[$];
  logic        hold16_p = 1'b0, hold32_p = 1'b0;
  logic [17:0] hold16;
  logic [33:0] hold32;

  always #5 clk = ~clk;

  csla_bec_pipe #(.WIDTH(16), .BLK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_cin(in_cin), .out_valid(ov16), .out_ready(out_ready), .out_sum(s16), .out_cout(c16)
`ifdef CSLA_OVF_EN
    , .out_ovf(f16)
`endif
  );

  csla_bec_pipe #(.WIDTH(32), .BLK(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .in_a(a32), .in_b(b32),
    .in_cin(in_cin), .out_valid(ov32), .out_ready(out_ready), .out_sum(s32), .out_cout(c32)
`ifdef CSLA_OVF_EN
    , .out_ovf(f32)
`endif
  );

`ifndef CSLA_OVF_EN
  assign f16 = 1'b0;
  assign f32 = 1'b0;
`endif

  // Reference: {ovf, cout, sum} from plain integer addition.
  function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [16:0] t;
    logic        v;
    t = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    v = (a[15] == b[15]) && (t[15] != a[15]);
`ifndef CSLA_OVF_EN
    v = 1'b0;
`endif
    return {v, t};
  endfunction

  function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] t;
    logic        v;
    t = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    v = (a[31] == b[31]) && (t[31] != a[31]);
`ifndef CSLA_OVF_EN
    v = 1'b0;
`endif
    return {v, t};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check held outputs, drive inputs at negedge, score handshakes for the coming edge.
  task automatic tick(input logic v, input logic ci, input logic ordy, input logic r,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] a2, input logic [31:0] b2);
    @(negedge clk);
    if (hold16_p) chk("hold16", {f16, c16, s16}, hold16);
    if (hold32_p) chk("hold32", {f32, c32, s32}, hold32);
    rst = r; in_valid = v; in_cin = ci; out_ready = ordy;
    a16 = a; b16 = b; a32 = a2; b32 = b2;
    #1;
    chk("in_ready16", ir16, !ov16 || ordy);
    chk("in_ready32", ir32, !ov32 || ordy);
    if (r) begin
      q16.delete();
      q32.delete();
    end else begin
      chk("spurious16", ov16 && (q16.size() == 0), 1'b0);
      chk("spurious32", ov32 && (q32.size() == 0), 1'b0);
      if (ov16 && q16.size() != 0) begin
        chk("out16", {f16, c16, s16}, q16[0]);
        if (ordy) void'(q16.pop_front());
      end
      if (ov32 && q32.size() != 0) begin
        chk("out32", {f32, c32, s32}, q32[0]);
        if (ordy) void'(q32.pop_front());
      end
      if (v && ir16) q16.push_back(ref16(a, b, ci));
      if (v && ir32) q32.push_back(ref32(a2, b2, ci));
    end
    hold16_p = !r && ov16 && !ordy;
    hold32_p = !r && ov32 && !ordy;
    hold16   = {f16, c16, s16};
    hold32   = {f32, c32, s32};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 16'($urandom), 16'($urandom), $urandom, $urandom);
  endtask

  task automatic lat_test(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic [15:0] es, input logic ec);
    tick(1'b1, ci, 1'b1, 1'b0, a, b, {16'hFFFF, a}, {16'h0000, b});
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 16'($urandom), 16'($urandom), $urandom, $urandom);
      chk("lat16", ov16, i == 4);
      chk("lat32", ov32, i == 8);
      if (i == 4) begin
        chk("ripple_sum16", s16, es);
        chk("ripple_cout16", c16, ec);
      end
      if (i == 8) begin
        chk("ripple_sum32", s32, 32'h0000_0000);
        chk("ripple_cout32", c32, 1'b1);
      end
    end
  endtask

  initial begin
    // Reset held two cycles with in_valid asserted
    tick(1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h4321, 32'h1, 32'h2);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 16'h5555, 16'hAAAA, 32'h3, 32'h4);
    @(posedge clk); #1;
    chk("rst_vld16", ov16, 1'b0);
    chk("rst_sum16", s16, 16'h0000);
    chk("rst_cout16", c16, 1'b0);
    chk("rst_ovf16", f16, 1'b0);
    chk("rst_rdy16", ir16, 1'b1);
    chk("rst_vld32", ov32, 1'b0);
    idle(6);

    // Full carry ripple, both via operand and via cin
    lat_test(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    lat_test(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // Back-to-back streaming
    for (int t = 0; t < 16; t++) begin
      tick(t < 8, 1'b0, 1'b1, 1'b0, 16'(t) * 16'h1111, 16'h0F0F, $urandom, $urandom);
      chk("stream_vld16", ov16, (t >= 4) && (t < 12));
    end

    // Backpressure with a full pipeline
    for (int t = 0; t < 10; t++) begin
      tick(1'b1, t[0], !((t >= 5) && (t < 8)), 1'b0, 16'($urandom), 16'($urandom), $urandom, $urandom);
      if (t >= 5 && t < 8) chk("bp_rdy16", ir16, 1'b0);
    end
    idle(12);
    chk("bp_drain16", q16.size(), 0);
    chk("bp_drain32", q32.size(), 0);

    // Reset with transactions in flight
    for (int t = 0; t < 3; t++) tick(1'b1, 1'b0, 1'b1, 1'b0, 16'($urandom), 16'($urandom), $urandom, $urandom);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'h1);
    @(posedge clk); #1;
    chk("midrst_vld16", ov16, 1'b0);
    chk("midrst_vld32", ov32, 1'b0);
    idle(10);

    // Signed overflow corners
    tick(1'b1, 1'b0, 1'b1, 1'b0, 16'h7FFF, 16'h0001, 32'h7FFF_FFFF, 32'h0000_0001);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 16'h8000, 16'hFFFF, 32'h8000_0000, 32'hFFFF_FFFF);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 16'hFFFE, 32'h0000_0003, 32'hFFFF_FFFE);
    idle(10);
`ifdef CSLA_OVF_EN
    chk("ovf_const", ref16(16'h8000, 16'hFFFF, 1'b0), {1'b1, 1'b1, 16'h7FFF});
`endif

    // Randomized traffic with random backpressure
    for (int t = 0; t < 400; t++)
      tick($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0, 1'b0,
           16'($urandom), 16'($urandom), $urandom, $urandom);
    idle(16);
    chk("rand_drain16", q16.size(), 0);
    chk("rand_drain32", q32.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/csla_bec_pipe.md
# csla_bec_pipe

Parametrised, pipelined carry-select adder. Each BLK-bit segment uses one ripple-carry adder with carry-in tied to 0. A binary-to-excess-1 converter (BEC) derives the carry-in = 1 result, and a 2:1 mux picks between the two using the carry from the previous segment. It is the width-generic, streaming successor of the fixed 4-bit CSLA-with-BEC cells. It feeds the recombination adders of the recursive Karatsuba multipliers, using a valid/ready handshake so it can sit in a stalled datapath.

## Interface
Parameters:
- WIDTH, 16: operand/sum width; must be a multiple of BLK.
- BLK, 4: segment width in bits; must be ≥ 2.

Derived:
- NSEG = WIDTH/BLK, the segment count and pipeline depth.

Ports:
- clk  in  1  Sole clock; all state changes on the rising edge.
- rst  in  1  Reset; synchronous, active-high.
- in_valid  in  1  An operand set is presented.
- in_ready  out  1  The block accepts the operand set this cycle.
- in_a  in  WIDTH  Operand A, unsigned / two's complement.
- in_b  in  WIDTH  Operand B.
- in_cin  in  1  Carry-in to segment 0.
- out_valid  out  1  out_sum / out_cout hold a result.
- out_ready  in  1  The consumer takes the result this cycle.
- out_sum  out  WIDTH  (in_a + in_b + in_cin) mod 2^WIDTH.
- out_cout  out  1  Carry out of the MSB.
- out_ovf  out  1  Signed overflow; present only with CSLA_OVF_EN.

## Operation
- Stage k (0..NSEG-1) adds segment k, bits [k*BLK +: BLK].
  - Stage 0 uses in_cin as its select.
  - Stage k > 0 uses the registered carry from stage k-1.
- Operands for segment j are skewed through j register slices before reaching stage j.
- Completed lower sum segments are deskewed, so all segments of one transaction exit together.
- Each stage computes:
  - s0,c0 = RCA(a_seg, b_seg, 0).
  - s1,c1 = BEC({c0,s0}).
  - {carry,sum} = sel ? {c1,s1} : {c0,s0}.
- Pipeline advance enable: en = !out_valid || out_ready.
  - in_ready = en.
  - Transfer into the block = in_valid && in_ready.
  - When en is low, every stage, including valid bits, holds.
- Bubbles are not collapsed. Valid bits shift with the data, one per stage.
- Results leave in input order. There is no loss or duplication under any out_ready pattern.

## Timing
- Latency: NSEG cycles from an accepted input to out_valid, with out_ready held high. Defaults: 4 cycles; WIDTH=32, BLK=4 gives 8.
- Throughput: one result per cycle while out_ready = 1.
- While out_valid && !out_ready:
  - out_sum, out_cout and out_ovf are stable.
  - in_ready = 0.
- Reset values: all stage valid bits 0, out_valid 0, out_sum 0, out_cout 0, out_ovf 0. in_ready reads 1 from the first cycle after reset.
- rst asserted mid-operation discards every in-flight transaction. in_valid is ignored while rst = 1.
- A simultaneous accept and output pop in the same cycle is legal and is the normal streaming case.
- The carry path is combinational only within one BLK segment. The critical path is RCA(BLK) + BEC + mux.

## Configuration
- CSLA_OVF_EN defined:
  - out_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]).
  - It is registered and deskewed alongside out_sum.
- CSLA_OVF_EN undefined: the out_ovf port and its logic are absent.

## Structure
- Package csla_pkg holds:
  - Function nseg(width, blk).
  - An elaboration check that WIDTH % BLK == 0 and BLK ≥ 2.
  - Localparam defaults.
- Sub-module csla_seg: one combinational BLK-bit segment (RCA with cin = 0, BLK+1-bit BEC, mux).
  - Instantiated NSEG times in a generate loop.
  - Skew, deskew and valid registers live in the top level.

## Test plan
- Reset: rst = 1 for 2 cycles with in_valid = 1 → out_valid = 0, out_sum = 0, out_cout = 0, in_ready = 1 after release; nothing emerges.
- Full carry ripple: a = 16'hFFFF, b = 16'h0001, cin = 0 → after 4 cycles out_sum = 16'h0000, out_cout = 1. Also a = 16'hFFFF, b = 0, cin = 1 gives the same result.
- Streaming: 8 back-to-back inputs, a = i*16'h1111, b = 16'h0F0F, out_ready = 1 → 8 consecutive valid outputs starting at cycle 4, in order, all sums correct.
- Backpressure: pipeline full, out_ready = 0 for 3 cycles → in_ready = 0, out_sum constant. After release, the remaining results emerge with none dropped or duplicated.
- Reset mid-flight: rst pulsed 1 cycle with 3 transactions in flight → out_valid = 0 the next cycle; those results never appear.
- CSLA_OVF_EN: 16'h7FFF + 16'h0001 → ovf = 1; 16'h8000 + 16'hFFFF → ovf = 1, cout = 1; 16'h0003 + 16'hFFFE → ovf = 0. Also run WIDTH = 32, BLK = 4 with randomized operands checked against a reference sum.
